alu_arbiter: RTL

- Shares one combinational ALU (4-bit op, 32-bit A/B, result C, NEG/ZERO flags) between two requesters, e.g. execute stage (req0) and address-gen unit (req1).
- Arbitrates round-robin, registers operands into the ALU, captures result and flags, and returns them on a valid/ready response channel tagged with requester ID and tag.
- Sits between the issue logic and the ALU instance in the CPU.

---
 rtl/alu_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU.
// Define ALU_FIXED_PRIO_EN for fixed priority (req0 wins); default is round-robin.
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4,
    parameter int TAG_W  = 4
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iReq0_Valid,
    output logic              oReq0_Ready,
    input  logic [OP_W-1:0]   iReq0_OP,
    input  logic [DATA_W-1:0] iReq0_A,
    input  logic [DATA_W-1:0] iReq0_B,
    input  logic [TAG_W-1:0]  iReq0_Tag,
    input  logic              iReq1_Valid,
    output logic              oReq1_Ready,
    input  logic [OP_W-1:0]   iReq1_OP,
    input  logic [DATA_W-1:0] iReq1_A,
    input  logic [DATA_W-1:0] iReq1_B,
    input  logic [TAG_W-1:0]  iReq1_Tag,
    output logic [OP_W-1:0]   oAluOP,
    output logic [DATA_W-1:0] oAluA,
    output logic [DATA_W-1:0] oAluB,
    input  logic [DATA_W-1:0] iAluC,
    input  logic              iAluNEG,
    input  logic              iAluZERO,
    output logic              oRsp_Valid,
    input  logic              iRsp_Ready,
    output logic              oRsp_ID,
    output logic [TAG_W-1:0]  oRsp_Tag,
    output logic [DATA_W-1:0] oRsp_C,
    output logic              oRsp_NEG,
    output logic              oRsp_ZERO,
    output logic              oBusy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic              w_win;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_gnt;
    logic              r_id;
    logic [TAG_W-1:0]  r_tag;
    logic [OP_W-1:0]   r_alu_op;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic              r_rsp_id;
    logic [TAG_W-1:0]  r_rsp_tag;
    logic [DATA_W-1:0] r_rsp_c;
    logic              r_rsp_neg;
    logic              r_rsp_zero;

`ifndef ALU_FIXED_PRIO_EN
    // Holds the ID of the last grant; on a tie the other side wins.
    logic r_ptr;
`endif

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        w_win  = iRst_n &&
                 ((r_state == IDLE) ||
                  ((r_state == RESP) && iRsp_Ready));
        if (w_win) begin
`ifdef ALU_FIXED_PRIO_EN
            w_gnt0 = iReq0_Valid;
            w_gnt1 = iReq1_Valid && !iReq0_Valid;
`else
            if (iReq0_Valid && iReq1_Valid) begin
                w_gnt0 = r_ptr;
                w_gnt1 = !r_ptr;
            end else begin
                w_gnt0 = iReq0_Valid;
                w_gnt1 = iReq1_Valid;
            end
`endif
        end
    end

    assign w_gnt = w_gnt0 | w_gnt1;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (w_gnt) w_state_nxt = EXEC;
            EXEC: w_state_nxt = RESP;
            RESP: begin
                if (iRsp_Ready) begin
                    w_state_nxt = w_gnt ? EXEC : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_state    <= IDLE;
            r_id       <= 1'b0;
            r_tag      <= '0;
            r_alu_op   <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_rsp_id   <= 1'b0;
            r_rsp_tag  <= '0;
            r_rsp_c    <= '0;
            r_rsp_neg  <= 1'b0;
            r_rsp_zero <= 1'b0;
`ifndef ALU_FIXED_PRIO_EN
            r_ptr      <= 1'b1;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_gnt) begin
                r_alu_op <= w_gnt1 ? iReq1_OP  : iReq0_OP;
                r_alu_a  <= w_gnt1 ? iReq1_A   : iReq0_A;
                r_alu_b  <= w_gnt1 ? iReq1_B   : iReq0_B;
                r_tag    <= w_gnt1 ? iReq1_Tag : iReq0_Tag;
                r_id     <= w_gnt1;
`ifndef ALU_FIXED_PRIO_EN
                r_ptr    <= w_gnt1;
`endif
            end
            // ALU has had one full cycle to settle on the registered operands.
            if (r_state == EXEC) begin
                r_rsp_c    <= iAluC;
                r_rsp_neg  <= iAluNEG;
                r_rsp_zero <= iAluZERO;
                r_rsp_id   <= r_id;
                r_rsp_tag  <= r_tag;
            end
        end
    end

    assign oReq0_Ready = w_gnt0;
    assign oReq1_Ready = w_gnt1;
    assign oAluOP      = r_alu_op;
    assign oAluA       = r_alu_a;
    assign oAluB       = r_alu_b;
    assign oRsp_Valid  = (r_state == RESP);
    assign oRsp_ID     = r_rsp_id;
    assign oRsp_Tag    = r_rsp_tag;
    assign oRsp_C      = r_rsp_c;
    assign oRsp_NEG    = r_rsp_neg;
    assign oRsp_ZERO   = r_rsp_zero;
    assign oBusy       = (r_state != IDLE);

endmodule
